hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Issue-gating scheduler sitting between the decode stage and execute stage of the 16-bit vector ASIP pipeline. Tracks in-flight register writes with per-register countdown scoreboards and serializes the single shared data-memory port between loads and SUPIX stores. Asserts `stall` to hold the decoded instruction whenever a RAW, WAW or memory-port hazard exists. Also reports idle status and a stall-cycle count for debug.

## Interface
- `NREG`, 16, number of architectural registers
- `REG_W`, 4, register index width (instruction[11:8] field)
- `CNT_W`, 2, scoreboard counter width
- `ALU_LAT`, 2, cycles until an ALU-sourced write is readable
- `MEM_LAT`, 3, cycles until a memory-sourced write is readable
- `IMM_LAT`, 1, cycles until an immediate-sourced (LOSC) write is readable
- `MEM_OCC`, 2, cycles the memory port stays occupied per access

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `issue_valid`  in  1  decode stage holds a valid instruction
- `src_a`, `src_b`  in  REG_W  source register indices
- `src_a_en`, `src_b_en`  in  1  source actually read
- `dst`  in  REG_W  destination register index
- `reg_write_en`  in  1  instruction writes `dst`
- `write_from`  in  2  00 memory, 01 ALU, 10 immediate, 11 reserved (treated as ALU)
- `mem_write`  in  1  instruction is SUPIX (memory store)
- `stall`  out  1  hold decode; instruction not issued this cycle
- `issued`  out  1  instruction accepted this cycle
- `busy_mask`  out  NREG  bit r set when scoreboard counter r ≠ 0
- `mem_busy`  out  1  memory-port occupancy counter ≠ 0
- `idle`  out  1  `busy_mask` == 0 and `mem_busy` == 0
- `stall_cycles`  out  16  saturating count of stalled cycles

## Operation
- Memory access = (`reg_write_en` and `write_from`==00) or `mem_write`.
- Hazards, evaluated combinationally from current state:
  - RAW: `src_a_en` and cnt[src_a]≠0, or `src_b_en` and cnt[src_b]≠0.
  - WAW: `reg_write_en` and cnt[dst]≠0.
  - Structural: memory access and mem_cnt≠0.
- `stall` = `issue_valid` and any hazard; `issued` = `issue_valid` and not `stall`.
- On `issued` with `reg_write_en`: cnt[dst] loads latency selected by `write_from` (00→MEM_LAT, 10→IMM_LAT, else ALU_LAT).
- On `issued` with memory access: mem_cnt loads MEM_OCC.
- Every other non-zero counter decrements by 1 per cycle; loads win over decrement for the same counter (cannot collide, since loads only occur at cnt==0).
- No bypassing: a register is readable only when its counter is 0.
- Instruction with both `mem_write` and `reg_write_en` is legal: both counters load.
- `stall_cycles` increments on each `stall` cycle, holds at 16'hFFFF.
- `issue_valid`=0: no hazard, `stall`=0, counters only decrement.

## Timing
- `stall`, `issued`, `idle` are combinational from inputs and registered state; counters, `busy_mask`, `mem_busy`, `stall_cycles` registered.
- Producer issued at cycle t with latency L: dependent reader can issue at cycle t+L+1.
- Memory access at cycle t: next memory access can issue at cycle t+MEM_OCC+1.
- Reset (asynchronous, any time, including mid-countdown): all counters 0, `busy_mask`=0, `mem_busy`=0, `stall_cycles`=0, so `idle`=1 and `stall`=0 immediately; in-flight tracking is discarded.
- Register 0 is tracked like any other register (no hardwired zero).

## Structure
- Shared package `asip_pkg`: `write_from_e` enum (MEM=00, ALU=01, IMM=10), latency constants, register index type, plus opcode constants shared with the decoder.
- Sub-module `reg_countdown`: one loadable, decrement-to-zero counter with `busy` output. Instantiated NREG times via generate for the register scoreboard and once for the memory port.

## Test plan
- ALU write r3 at t, then reader of r3 asserted continuously → `stall`=1 at t+1..t+2, `issued` at t+3; `busy_mask[3]` high t+1..t+2.
- Load (write_from=00) r5 followed by unrelated load r6 → second load stalls 2 cycles on `mem_busy`, then issues; `busy_mask` shows bits 5 and 6 staggered.
- LOSC r1 (IMM_LAT=1) then write r1 via ALU → WAW stall exactly 1 cycle.
- Independent ALU instructions every cycle on distinct registers → `stall` never asserted, `stall_cycles` stays 0.
- Assert `rst` mid-countdown with `busy_mask`=16'h0028 → outputs clear asynchronously, `idle`=1, blocked reader issues in the first cycle after release.
- Force 70000 stalled cycles → `stall_cycles` saturates at 16'hFFFF.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared ASIP definitions: register/latency constants, write-source encoding,
// and opcode values used by both the decoder and the hazard scheduler.
package asip_pkg;

    localparam int unsigned NREG    = 16;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned ALU_LAT = 2;
    localparam int unsigned MEM_LAT = 3;
    localparam int unsigned IMM_LAT = 1;
    localparam int unsigned MEM_OCC = 2;
    localparam int unsigned SC_W    = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        WF_MEM = 2'b00,
        WF_ALU = 2'b01,
        WF_IMM = 2'b10
    } write_from_e;

    // Decoder opcode field values (instruction[15:12])
    localparam logic [3:0] OP_ALU   = 4'h0;
    localparam logic [3:0] OP_LOSC  = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_SUPIX = 4'h3;

    // Readiness latency for a register write; the reserved code 11 behaves as ALU
    function automatic logic [CNT_W-1:0] write_latency(input logic [1:0] wf);
        case (wf)
            WF_MEM:  return CNT_W'(MEM_LAT);
            WF_IMM:  return CNT_W'(IMM_LAT);
            default: return CNT_W'(ALU_LAT);
        endcase
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode-to-scheduler issue interface: instruction hazard fields in, gating and
// debug status out.
interface hazard_scheduler_if;
    import asip_pkg::*;

    logic                 issue_valid;
    reg_idx_t             src_a;
    reg_idx_t             src_b;
    logic                 src_a_en;
    logic                 src_b_en;
    reg_idx_t             dst;
    logic                 reg_write_en;
    logic [1:0]           write_from;
    logic                 mem_write;

    logic                 stall;
    logic                 issued;
    logic [NREG-1:0]      busy_mask;
    logic                 mem_busy;
    logic                 idle;
    logic [SC_W-1:0]      stall_cycles;

    modport master (
        output issue_valid, src_a, src_b, src_a_en, src_b_en,
               dst, reg_write_en, write_from, mem_write,
        input  stall, issued, busy_mask, mem_busy, idle, stall_cycles
    );

    modport slave (
        input  issue_valid, src_a, src_b, src_a_en, src_b_en,
               dst, reg_write_en, write_from, mem_write,
        output stall, issued, busy_mask, mem_busy, idle, stall_cycles
    );

endinterface

// File: rtl/reg_countdown.sv
// Loadable countdown to zero; busy while non-zero. A load takes priority over
// the decrement.
module reg_countdown #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Decode/execute issue gate: per-register write scoreboard plus a shared
// memory-port occupancy counter; stalls on RAW, WAW or memory-port conflicts.
module hazard_scheduler
    import asip_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    hazard_scheduler_if.slave bus
);

    logic [NREG-1:0]  reg_busy;
    logic             port_busy;
    logic             mem_access;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             port_hazard;
    logic             stall;
    logic             issued;
    logic [CNT_W-1:0] dst_latency;
    logic [SC_W-1:0]  stall_cnt;

    // Hazard evaluation from the current scoreboard state (no bypassing)
    always_comb begin
        mem_access  = (bus.reg_write_en && (bus.write_from == 2'(WF_MEM))) || bus.mem_write;
        raw_hazard  = (bus.src_a_en && reg_busy[bus.src_a]) ||
                      (bus.src_b_en && reg_busy[bus.src_b]);
        waw_hazard  = bus.reg_write_en && reg_busy[bus.dst];
        port_hazard = mem_access && port_busy;
        stall       = bus.issue_valid && (raw_hazard || waw_hazard || port_hazard);
        issued      = bus.issue_valid && !stall;
        dst_latency = write_latency(bus.write_from);
    end

    for (genvar r = 0; r < NREG; r++) begin : g_reg_sb
        reg_countdown #(.W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (issued && bus.reg_write_en && (bus.dst == REG_W'(r))),
            .load_val (dst_latency),
            .busy     (reg_busy[r])
        );
    end

    reg_countdown #(.W(CNT_W)) u_mem_port (
        .clk      (clk),
        .rst      (rst),
        .load     (issued && mem_access),
        .load_val (CNT_W'(MEM_OCC)),
        .busy     (port_busy)
    );

    // Saturating debug count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {SC_W{1'b1}})) begin
            stall_cnt <= stall_cnt + SC_W'(1);
        end
    end

    assign bus.stall        = stall;
    assign bus.issued       = issued;
    assign bus.busy_mask    = reg_busy;
    assign bus.mem_busy     = port_busy;
    assign bus.idle         = (reg_busy == '0) && !port_busy;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: latency/stall timing, memory-port
// serialization, asynchronous reset and stall counter saturation.
module tb_hazard_scheduler;
    import asip_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    hazard_scheduler_if bus ();

    hazard_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sa, input logic sae,
                         input logic [3:0] sb, input logic sbe, input logic [3:0] d,
                         input logic we, input logic [1:0] wf, input logic mw);
        bus.issue_valid  = v;
        bus.src_a        = sa;
        bus.src_a_en     = sae;
        bus.src_b        = sb;
        bus.src_b_en     = sbe;
        bus.dst          = d;
        bus.reg_write_en = we;
        bus.write_from   = wf;
        bus.mem_write    = mw;
        #1;
    endtask

    task automatic drive_none();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'b01, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!bus.idle && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.idle), 32'd1);
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive_none();
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", 32'(bus.idle), 32'd1);
        check("reset_busy_mask", 32'(bus.busy_mask), 32'h0);
        check("reset_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b0;
        #1;

        // ALU write r3, then continuous reader of r3
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 2'b01, 1'b0);
        check("alu_w3_issued", 32'(bus.issued), 32'd1);
        tick();
        drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 2'b01, 1'b0);
        check("raw_t1_stall", 32'(bus.stall), 32'd1);
        check("raw_t1_mask", 32'(bus.busy_mask), 32'h0008);
        tick();
        check("raw_t2_stall", 32'(bus.stall), 32'd1);
        check("raw_t2_mask", 32'(bus.busy_mask), 32'h0008);
        tick();
        check("raw_t3_issued", 32'(bus.issued), 32'd1);
        check("raw_t3_mask", 32'(bus.busy_mask), 32'h0);
        check("raw_stall_cycles", 32'(bus.stall_cycles), 32'd2);
        tick();
        drive_none();
        wait_idle("raw_drain");

        // Load r5 then unrelated load r6: port busy for two cycles
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 2'b00, 1'b0);
        check("ld5_issued", 32'(bus.issued), 32'd1);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 2'b00, 1'b0);
        check("ld6_t1_stall", 32'(bus.stall), 32'd1);
        check("ld6_t1_mem_busy", 32'(bus.mem_busy), 32'd1);
        check("ld6_t1_mask", 32'(bus.busy_mask), 32'h0020);
        tick();
        check("ld6_t2_stall", 32'(bus.stall), 32'd1);
        tick();
        check("ld6_t3_issued", 32'(bus.issued), 32'd1);
        check("ld6_t3_mask", 32'(bus.busy_mask), 32'h0020);
        tick();
        drive_none();
        check("ld6_t4_mask", 32'(bus.busy_mask), 32'h0040);
        check("ld_stall_cycles", 32'(bus.stall_cycles), 32'd4);
        wait_idle("ld_drain");

        // LOSC r1 then ALU write r1: one-cycle WAW
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 2'b10, 1'b0);
        check("losc_issued", 32'(bus.issued), 32'd1);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 2'b01, 1'b0);
        check("waw_t1_stall", 32'(bus.stall), 32'd1);
        tick();
        check("waw_t2_issued", 32'(bus.issued), 32'd1);
        tick();
        drive_none();
        check("waw_stall_cycles", 32'(bus.stall_cycles), 32'd5);
        wait_idle("waw_drain");

        // Store plus load-writeback in one instruction: both trackers load
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 2'b00, 1'b1);
        check("st_ld_issued", 32'(bus.issued), 32'd1);
        tick();
        drive_none();
        check("st_ld_mask", 32'(bus.busy_mask), 32'h0004);
        check("st_ld_mem_busy", 32'(bus.mem_busy), 32'd1);
        wait_idle("st_ld_drain");

        // Independent ALU ops every cycle never stall
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 1'b1, 4'(i), 1'b1, 4'(8 + i), 1'b1, 2'b11, 1'b0);
            check($sformatf("indep_%0d_issued", i), 32'(bus.issued), 32'd1);
            tick();
        end
        drive_none();
        check("indep_stall_cycles", 32'(bus.stall_cycles), 32'd5);
        wait_idle("indep_drain");

        // Reset mid-countdown with r3 and r5 in flight
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 2'b00, 1'b0);
        tick();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 2'b01, 1'b0);
        check("rst_pre_alu_issued", 32'(bus.issued), 32'd1);
        tick();
        drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 2'b01, 1'b0);
        check("rst_pre_mask", 32'(bus.busy_mask), 32'h0028);
        check("rst_pre_stall", 32'(bus.stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_mask", 32'(bus.busy_mask), 32'h0);
        check("rst_async_mem_busy", 32'(bus.mem_busy), 32'd0);
        check("rst_async_idle", 32'(bus.idle), 32'd1);
        check("rst_async_stall", 32'(bus.stall), 32'd0);
        check("rst_async_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_release_issued", 32'(bus.issued), 32'd1);
        tick();
        drive_none();
        wait_idle("rst_drain");

        // Self-dependent load on r5: three stalls per issue until saturation
        drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 2'b00, 1'b0);
        n = 0;
        while (bus.stall_cycles != 16'hFFFF && n < 95000) begin
            tick();
            n++;
        end
        check("sat_reached", 32'(bus.stall_cycles), 32'h0000FFFF);
        repeat (12) tick();
        check("sat_hold", 32'(bus.stall_cycles), 32'h0000FFFF);
        drive_none();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
